core_rf_wb_arbiter: RTL

//  Shares the single write port of core_id_regfile between two writeback sources:
//  - the ALU pipeline (fixed latency, top priority);
//  - ring-network load returns (variable latency, buffered in a small FIFO).

---
 rtl/core_rf_pkg.sv | 13 +
 rtl/core_rf_wb_fifo.sv | 54 +++++
 rtl/core_rf_wb_arbiter.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/core_rf_pkg.sv
// Shared types and widths for the regfile writeback arbiter and its load-return FIFO.
package core_rf_pkg;

  localparam int RF_ADDR_W = 5;
  localparam int RF_DATA_W = 32;
  localparam int RF_NREGS  = 32;

  typedef struct packed {
    logic [RF_ADDR_W-1:0] addr;
    logic [RF_DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/core_rf_wb_fifo.sv
// Small count-based FIFO buffering load returns until the regfile write port is free.
module core_rf_wb_fifo
  import core_rf_pkg::*;
#(
  parameter int LQ_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        push,
  input  logic                        pop,
  input  wb_entry_t                   wr_entry,
  output wb_entry_t                   rd_entry,
  output logic                        full,
  output logic                        empty,
  output logic [$clog2(LQ_DEPTH):0]   count
);

  localparam int PTR_W = $clog2(LQ_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wb_entry_t          mem [LQ_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic               do_push;
  logic               do_pop;

  assign full     = (count == CNT_W'(LQ_DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign rd_entry = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; pointers and count define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_entry;
  end

endmodule

// File: rtl/core_rf_wb_arbiter.sv
// Arbitrates the regfile write port between ALU writeback and buffered load returns; tracks pending loads.
// Optional CORE_RF_ARB_BYPASS_EN lets a return skip the empty FIFO when the port is idle.
module core_rf_wb_arbiter
  import core_rf_pkg::*;
#(
  parameter int LQ_DEPTH     = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 alu_wr_valid,
  input  logic [RF_ADDR_W-1:0] alu_wr_addr,
  input  logic [RF_DATA_W-1:0] alu_wr_data,
  output logic                 alu_stall,
  input  logic                 mem_wr_valid,
  input  logic [RF_ADDR_W-1:0] mem_wr_addr,
  input  logic [RF_DATA_W-1:0] mem_wr_data,
  output logic                 mem_wr_ready,
  input  logic                 ld_issue,
  input  logic [RF_ADDR_W-1:0] ld_issue_rd,
  input  logic [RF_ADDR_W-1:0] chk_addr1,
  input  logic [RF_ADDR_W-1:0] chk_addr2,
  output logic                 chk_busy1,
  output logic                 chk_busy2,
  output logic                 rf_write,
  output logic [RF_ADDR_W-1:0] waddr,
  output logic [RF_DATA_W-1:0] data
);

  localparam int CNT_W = $clog2(LQ_DEPTH) + 1;
  localparam int ST_W  = $clog2(STARVE_LIMIT);

  wb_entry_t           push_entry;
  wb_entry_t           head;
  logic                push;
  logic                pop;
  logic                full;
  logic                empty;
  logic [CNT_W-1:0]    count;
  logic                grant_alu;
  logic                bypass;
  logic                starving;
  logic [ST_W-1:0]     starve_cnt;
  logic [ST_W-1:0]     cnt_inc;
  logic [RF_NREGS-1:0] pending;
  logic [RF_NREGS-1:0] pending_nxt;

  assign mem_wr_ready = (count != CNT_W'(LQ_DEPTH));
  assign push_entry   = '{addr: mem_wr_addr, data: mem_wr_data};
  assign push         = mem_wr_valid && mem_wr_ready && !bypass;

`ifdef CORE_RF_ARB_BYPASS_EN
  assign bypass = mem_wr_valid && empty && !alu_wr_valid && !alu_stall;
`else
  assign bypass = 1'b0;
`endif

  core_rf_wb_fifo #(
    .LQ_DEPTH (LQ_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .pop      (pop),
    .wr_entry (push_entry),
    .rd_entry (head),
    .full     (full),
    .empty    (empty),
    .count    (count)
  );

  // A starvation stall forces one FIFO drain even with an ALU request present.
  always_comb begin
    pop       = 1'b0;
    grant_alu = 1'b0;
    if (alu_stall && !empty)  pop       = 1'b1;
    else if (alu_wr_valid)    grant_alu = 1'b1;
    else if (!empty)          pop       = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rf_write <= 1'b0;
      waddr    <= '0;
      data     <= '0;
    end else begin
      rf_write <= grant_alu || pop || bypass;
      if (grant_alu) begin
        waddr <= alu_wr_addr;
        data  <= alu_wr_data;
      end else if (pop) begin
        waddr <= head.addr;
        data  <= head.data;
      end else if (bypass) begin
        waddr <= mem_wr_addr;
        data  <= mem_wr_data;
      end
    end
  end

  assign starving = !empty && !pop;
  assign cnt_inc  = starve_cnt + 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt <= '0;
      alu_stall  <= 1'b0;
    end else if (!starving) begin
      starve_cnt <= '0;
      alu_stall  <= 1'b0;
    end else if (cnt_inc == ST_W'(STARVE_LIMIT - 1)) begin
      starve_cnt <= '0;
      alu_stall  <= 1'b1;
    end else begin
      starve_cnt <= cnt_inc;
      alu_stall  <= 1'b0;
    end
  end

  // Set is applied after clear so a re-issue in the retiring cycle stays pending.
  always_comb begin
    pending_nxt = pending;
    if (pop)    pending_nxt[head.addr]   = 1'b0;
    if (bypass) pending_nxt[mem_wr_addr] = 1'b0;
    if (ld_issue && ld_issue_rd != '0) pending_nxt[ld_issue_rd] = 1'b1;
    pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pending <= '0;
    else      pending <= pending_nxt;
  end

  assign chk_busy1 = pending[chk_addr1];
  assign chk_busy2 = pending[chk_addr2];

  a_no_reissue_pending: assert property (@(posedge clk) disable iff (!rst)
    (ld_issue && ld_issue_rd != '0) |-> !pending[ld_issue_rd]);

  a_no_push_full: assert property (@(posedge clk) disable iff (!rst)
    !(push && full));

endmodule
